// File: rtl/ped_if_pkg.sv
// ped_if_pkg: shared FSM state type and default parameters for the pedestrian button block.
package ped_if_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, WALK, COOLDOWN} state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int COOLDOWN_CYCLES_DEF = 16;
  localparam int TIMEOUT_CYCLES_DEF  = 64;
  localparam int WAIT_W_DEF          = 8;
endpackage

// File: rtl/ped_button_interface_if.sv
// ped_button_interface_if: button, controller handshake and status signals of the pedestrian block.
interface ped_button_interface_if #(parameter int WAIT_W = ped_if_pkg::WAIT_W_DEF);
  logic              button_raw;
  logic              emergency;
  logic              pedestrian_walk;
  logic              pedestrian_request;
  logic              wait_lamp;
  logic [WAIT_W-1:0] wait_cycles;
  logic              wait_timeout;
  logic              serviced;
  modport master(output button_raw, emergency, pedestrian_walk,
                 input pedestrian_request, wait_lamp, wait_cycles, wait_timeout, serviced);
  modport slave(input button_raw, emergency, pedestrian_walk,
                output pedestrian_request, wait_lamp, wait_cycles, wait_timeout, serviced);
endinterface

// File: rtl/ped_debounce.sv
// ped_debounce: two-flop synchronizer, stable-high debounce counter and press-edge pulse.
module ped_debounce #(
  parameter int DEBOUNCE_CYCLES = ped_if_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], button_raw};
      cnt     <= !sync[1] ? '0 : (cnt == CW'(DEBOUNCE_CYCLES)) ? cnt : cnt + 1'b1;
      level   <= sync[1] && cnt == CW'(DEBOUNCE_CYCLES);
      level_q <= level;
    end
  end
  assign press = level && !level_q;
endmodule

// File: rtl/ped_button_interface.sv
// ped_button_interface: debounced pedestrian request FSM with wait tracking and post-walk cooldown.
module ped_button_interface
  import ped_if_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int WAIT_W          = WAIT_W_DEF
) (
  input logic clk,
  input logic rst,
  ped_button_interface_if.slave bus
);
  localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);
  state_e            state, state_n;
  logic              level, press, press_ev, go, clr, timeout_q;
  logic [CDW-1:0]    cd;
  logic [WAIT_W-1:0] wait_q, wait_inc;
  ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk), .rst(rst), .button_raw(bus.button_raw), .level(level), .press(press)
  );
  assign press_ev = press && level;
  assign wait_inc = &wait_q ? wait_q : wait_q + 1'b1;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    go      = state == ARMED && bus.pedestrian_walk && !bus.emergency;
    state_n = state == IDLE  ? (press_ev ? ARMED : IDLE) :
              state == ARMED ? (go ? WALK : ARMED) :
              state == WALK  ? (bus.pedestrian_walk ? WALK : COOLDOWN) :
                               (cd == '0 ? IDLE : COOLDOWN);
    clr     = state == IDLE || state_n == IDLE;
  end
  // wait stats hold through WALK/COOLDOWN and are cleared whenever IDLE is occupied or entered
  always_ff @(posedge clk) begin
    if (rst) begin
      cd        <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      cd        <= (state == WALK && !bus.pedestrian_walk) ? CDW'(COOLDOWN_CYCLES - 1) :
                   (state == COOLDOWN && cd != '0) ? cd - 1'b1 : cd;
      wait_q    <= clr ? '0 : state == ARMED ? wait_inc : wait_q;
      timeout_q <= clr ? 1'b0 : (state == ARMED && int'(wait_inc) == TIMEOUT_CYCLES) || timeout_q;
    end
  end
  assign bus.pedestrian_request = state == ARMED && !bus.emergency;
  assign bus.wait_lamp          = state == ARMED;
  assign bus.serviced           = go;
  assign bus.wait_cycles        = wait_q;
  assign bus.wait_timeout       = timeout_q;
endmodule

// File: doc/ped_button_interface.md
PED_BUTTON_INTERFACE -- requirements
Module: ped_button_interface

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable-high cycles needed to accept a press.
REQ-003 Parameter COOLDOWN_CYCLES, default 16: cycles after walk ends during which presses are ignored.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: wait length at which wait_timeout asserts.
REQ-005 Parameter WAIT_W, default 8: width of wait_cycles.
REQ-006 clk  input  1  rising-edge clock, 10 ns nominal.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 button_raw  input  1  asynchronous, bouncing pedestrian push-button.
REQ-009 emergency  input  1  emergency preemption, shared with the controller.
REQ-010 pedestrian_walk  input  1  walk indication from the controller; serves as request acknowledge.
REQ-011 pedestrian_request  output  1  request to the controller, level, registered.
REQ-012 wait_lamp  output  1  "request registered" lamp for the pedestrian.
REQ-013 wait_cycles  output  WAIT_W  cycles spent waiting for the current request, saturating.
REQ-014 wait_timeout  output  1  sticky flag: current wait reached TIMEOUT_CYCLES.
REQ-015 serviced  output  1  single-cycle pulse when a request is acknowledged.

Function
REQ-016 button_raw SHALL pass through a two-flop synchronizer before any other use.
REQ-017 Debounce: counter increments while synchronized button is 1 and clears to 0 on 0; debounced level rises when count reaches DEBOUNCE_CYCLES, falls on the first synchronized 0.
REQ-018 A press event SHALL be the rising edge of the debounced level: one event per press, regardless of hold length.
REQ-019 Latency: button_raw sampled high at edge 0 and held -> pedestrian_request high after edge 3+DEBOUNCE_CYCLES (edge 7 at defaults).
REQ-020 FSM states: IDLE, ARMED, WALK, COOLDOWN.
REQ-021 IDLE -> ARMED on press event; all outputs low in IDLE.
REQ-022 ARMED: wait_lamp=1; pedestrian_request=1 unless emergency=1 (then 0, request stays pending); wait_cycles increments each cycle, saturates at 2^WAIT_W-1.
REQ-023 ARMED -> WALK when pedestrian_walk=1 and emergency=0; serviced pulses for exactly that transition cycle; pedestrian_request, wait_lamp drop on the next edge.
REQ-024 pedestrian_walk=1 while in IDLE or COOLDOWN SHALL be ignored (no serviced, no state change).
REQ-025 Further press events in ARMED or WALK SHALL be coalesced (no effect).
REQ-026 WALK -> COOLDOWN when pedestrian_walk=0; cooldown counter loads COOLDOWN_CYCLES-1.
REQ-027 COOLDOWN decrements to 0 then -> IDLE; press events during COOLDOWN are discarded, not queued.
REQ-028 wait_timeout SET when wait_cycles reaches TIMEOUT_CYCLES in ARMED; held through WALK; cleared on entering ARMED.
REQ-029 wait_cycles SHALL hold its final value through WALK and COOLDOWN and clear to 0 on entering ARMED.
REQ-030 Simultaneous press event and COOLDOWN expiry: event discarded, state -> IDLE.
REQ-031 emergency=1 with pedestrian_walk=1 in ARMED: stay ARMED, no serviced.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, clear synchronizer, debounce, cooldown and wait counters, and drive all outputs to 0 on that edge.
REQ-033 Reset mid-request SHALL drop the request; a button held through reset deassertion SHALL produce a new press only after a full debounce from the first post-reset sample.

Structure
REQ-034 Package ped_if_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-035 Synchronizer plus debounce SHALL be a sub-module ped_debounce (parameter DEBOUNCE_CYCLES; outputs level and press pulse).

Verification (defaults)
REQ-036 Reset: rst high 2 cycles -> all outputs 0, state IDLE.
REQ-037 Bounce: button_raw toggles every cycle for 20 cycles -> no press, pedestrian_request stays 0.
REQ-038 Clean press held 10 cycles from edge 0 -> pedestrian_request rises after edge 7; pedestrian_walk pulsed 5 cycles at edge 20 -> serviced one cycle, wait_cycles=13.
REQ-039 Emergency: ARMED, emergency=1 for 8 cycles with pedestrian_walk=1 -> pedestrian_request 0, no serviced; emergency drops -> pedestrian_request 1, walk acknowledges.
REQ-040 Cooldown: press 5 cycles after walk ends -> ignored; press 20 cycles after -> ARMED.
REQ-041 Timeout: ARMED with no walk for 70 cycles -> wait_timeout=1 at wait_cycles=64, held until next ARMED entry; 300 cycles -> wait_cycles saturates at 255.
